// File: rtl/msg_pkg.sv
// Shared types and constants for the GPIO message transmit arbiter.
// Messages are stored first character in [7:0] and padded with spaces.
package msg_pkg;

   localparam int MSG_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } tx_state_t;

   localparam logic [MSG_W-1:0] SPACES_128    = {16{8'h20}};
   localparam logic [MSG_W-1:0] PRESET_SMILEY = {{14{8'h20}}, 8'h29, 8'h3A};
   localparam logic [MSG_W-1:0] PRESET_FROWN  = {{14{8'h20}}, 8'h28, 8'h3A};
   // "i'm busy, ttyl!" written last character first so 'i' lands in [7:0]
   localparam logic [MSG_W-1:0] PRESET_BUSY   = {8'h20, 8'h21, 8'h6C, 8'h79,
                                                 8'h74, 8'h74, 8'h20, 8'h2C,
                                                 8'h79, 8'h73, 8'h75, 8'h62,
                                                 8'h20, 8'h6D, 8'h27, 8'h69};

   function automatic logic [MSG_W-1:0] preset_rom(input logic [1:0] sel);
      logic [MSG_W-1:0] msg;
      case (sel)
         2'b00:   msg = PRESET_SMILEY;
         2'b01:   msg = PRESET_FROWN;
         2'b10:   msg = PRESET_BUSY;
         default: msg = SPACES_128;
      endcase
      return msg;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: grant 0 selects req[0], grant 1 selects req[1].
// On a tie the side that did not win last time is chosen.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   // Winner select; a lone requester always wins.
   always_comb begin
      grant = 1'b0;
      if (req == 2'b11) begin
         grant = ~last;
      end else begin
         grant = req[1];
      end
   end

endmodule

// File: rtl/msg_tx_arbiter.sv
// Shares the GPIO message transmitter between the keyboard composer and the
// preset selector. Timeout resends are enabled by defining MSG_TX_ARB_RETRY_EN.
module msg_tx_arbiter
   import msg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int MAX_RETRY      = 3,
   parameter int GAP_CYCLES     = 16
) (
   input  logic             clock,
   input  logic             RESETN,
   input  logic             req_kbd,
   input  logic [MSG_W-1:0] msg_kbd,
   input  logic             req_preset,
   input  logic [1:0]       preset_sel,
   input  logic             done,
   output logic             data_ready,
   output logic [MSG_W-1:0] message_out,
   output logic             ack_kbd,
   output logic             ack_preset,
   output logic             tx_ok,
   output logic             tx_err,
   output logic             busy,
   output logic             last_grant
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(TIMEOUT_CYCLES);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   tx_state_t        state_r;
   tx_state_t        state_s;
   logic             win_s;
   logic             grant_r;
   logic [TMR_W-1:0] timer_r;
   logic [GAP_W-1:0] gap_cnt_r;
   logic             resend_r;
   logic             done_q_r;
   logic             done_rise_s;
   logic             timeout_s;
   logic             gap_end_s;
   logic             retry_ok_s;
   logic             tx_ok_s;
   logic             tx_err_s;
   logic             resend_s;

   logic             data_ready_r;
   logic [MSG_W-1:0] message_r;
   logic             ack_kbd_r;
   logic             ack_preset_r;
   logic             tx_ok_r;
   logic             tx_err_r;
   logic             busy_r;
   logic             last_grant_r;

   rr_arb2 u_rr_arb2 (
      .req   ({req_preset, req_kbd}),
      .last  (last_grant_r),
      .grant (win_s)
   );

   assign done_rise_s = done & ~done_q_r;
   assign timeout_s   = (timer_r == TMR_LAST);
   assign gap_end_s   = (gap_cnt_r == GAP_LAST);

`ifdef MSG_TX_ARB_RETRY_EN
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

   logic [RTY_W-1:0] retry_cnt_r;

   assign retry_ok_s = (retry_cnt_r < RTY_MAX);

   // Resend attempts used by the message currently latched.
   always_ff @(posedge clock or negedge RESETN) begin
      if (!RESETN) begin
         retry_cnt_r <= '0;
      end else if (state_r == ST_LOAD) begin
         retry_cnt_r <= '0;
      end else if (resend_s) begin
         retry_cnt_r <= retry_cnt_r + RTY_W'(1);
      end else begin
         retry_cnt_r <= retry_cnt_r;
      end
   end
`else
   assign retry_ok_s = 1'b0;
`endif

   // Next-state and single-cycle event decode; done beats a same-cycle timeout.
   always_comb begin
      state_s  = state_r;
      tx_ok_s  = 1'b0;
      tx_err_s = 1'b0;
      resend_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_kbd | req_preset) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: state_s = ST_SEND;
         ST_SEND: begin
            if (done_rise_s) begin
               state_s = ST_GAP;
               tx_ok_s = 1'b1;
            end else if (timeout_s) begin
               state_s = ST_GAP;
               if (retry_ok_s) begin
                  resend_s = 1'b1;
               end else begin
                  tx_err_s = 1'b1;
               end
            end else begin
               state_s = ST_SEND;
            end
         end
         ST_GAP: begin
            if (gap_end_s) begin
               state_s = resend_r ? ST_SEND : ST_IDLE;
            end else begin
               state_s = ST_GAP;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register, done history for edge detection, and the captured winner.
   always_ff @(posedge clock or negedge RESETN) begin
      if (!RESETN) begin
         state_r  <= ST_IDLE;
         done_q_r <= 1'b0;
         grant_r  <= 1'b0;
      end else begin
         state_r  <= state_s;
         done_q_r <= done;
         if (state_r == ST_IDLE) begin
            grant_r <= win_s;
         end else begin
            grant_r <= grant_r;
         end
      end
   end

   // Attempt timer, gap counter and the resend-after-gap flag.
   always_ff @(posedge clock or negedge RESETN) begin
      if (!RESETN) begin
         timer_r   <= '0;
         gap_cnt_r <= '0;
         resend_r  <= 1'b0;
      end else begin
         if (state_r == ST_SEND) begin
            timer_r <= (timer_r != TMR_SAT) ? timer_r + TMR_W'(1) : timer_r;
         end else begin
            timer_r <= '0;
         end
         if (state_r == ST_GAP) begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
         end else begin
            gap_cnt_r <= '0;
         end
         if (state_r == ST_LOAD) begin
            resend_r <= 1'b0;
         end else if ((state_r == ST_SEND) && (state_s == ST_GAP)) begin
            resend_r <= resend_s;
         end else begin
            resend_r <= resend_r;
         end
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge clock or negedge RESETN) begin
      if (!RESETN) begin
         data_ready_r <= 1'b0;
         busy_r       <= 1'b0;
         ack_kbd_r    <= 1'b0;
         ack_preset_r <= 1'b0;
         tx_ok_r      <= 1'b0;
         tx_err_r     <= 1'b0;
         message_r    <= SPACES_128;
         last_grant_r <= 1'b1;
      end else begin
         data_ready_r <= (state_s == ST_SEND);
         busy_r       <= (state_s != ST_IDLE);
         ack_kbd_r    <= (state_r == ST_IDLE) && (state_s == ST_LOAD) && !win_s;
         ack_preset_r <= (state_r == ST_IDLE) && (state_s == ST_LOAD) && win_s;
         tx_ok_r      <= tx_ok_s;
         tx_err_r     <= tx_err_s;
         if (state_r == ST_LOAD) begin
            message_r    <= grant_r ? preset_rom(preset_sel) : msg_kbd;
            last_grant_r <= grant_r;
         end else begin
            message_r    <= message_r;
            last_grant_r <= last_grant_r;
         end
      end
   end

   assign data_ready  = data_ready_r;
   assign message_out = message_r;
   assign ack_kbd     = ack_kbd_r;
   assign ack_preset  = ack_preset_r;
   assign tx_ok       = tx_ok_r;
   assign tx_err      = tx_err_r;
   assign busy        = busy_r;
   assign last_grant  = last_grant_r;

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// Self-checking bench for msg_tx_arbiter: directed scenarios plus random traffic
// compared every cycle against a timestamp-based behavioural model.
module tb_msg_tx_arbiter;

   localparam int T_CYC = 20;
   localparam int G_CYC = 16;
`ifdef MSG_TX_ARB_RETRY_EN
   localparam int EFF_RETRY = 2;
`else
   localparam int EFF_RETRY = 0;
`endif

   logic         clock = 1'b0;
   logic         RESETN = 1'b0;
   logic         req_kbd = 1'b0;
   logic [127:0] msg_kbd = 128'd0;
   logic         req_preset = 1'b0;
   logic [1:0]   preset_sel = 2'b00;
   logic         done = 1'b0;
   logic         data_ready;
   logic [127:0] message_out;
   logic         ack_kbd;
   logic         ack_preset;
   logic         tx_ok;
   logic         tx_err;
   logic         busy;
   logic         last_grant;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   msg_tx_arbiter #(.TIMEOUT_CYCLES(T_CYC), .MAX_RETRY(2), .GAP_CYCLES(G_CYC)) dut (
      .clock(clock), .RESETN(RESETN), .req_kbd(req_kbd), .msg_kbd(msg_kbd),
      .req_preset(req_preset), .preset_sel(preset_sel), .done(done),
      .data_ready(data_ready), .message_out(message_out), .ack_kbd(ack_kbd),
      .ack_preset(ack_preset), .tx_ok(tx_ok), .tx_err(tx_err), .busy(busy),
      .last_grant(last_grant)
   );

   always #5 clock = ~clock;

   // Text to message: character i in byte i, remaining bytes are spaces.
   function automatic logic [127:0] text_msg(input string s);
      logic [127:0] m;
      m = {16{8'h20}};
      for (int i = 0; i < s.len() && i < 16; i++) m[i*8 +: 8] = s[i];
      return m;
   endfunction

   function automatic logic [127:0] preset_text(input logic [1:0] sel);
      case (sel)
         2'b00:   return text_msg(":)");
         2'b01:   return text_msg(":(");
         2'b10:   return text_msg("i'm busy, ttyl!");
         default: return text_msg("");
      endcase
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: cycle stamps for the send window, gap end and idle time.
   int           m_c, m_load_at, m_from, m_to, m_att, m_free_at;
   bit           m_active, m_win, m_done_prev;
   logic         e_drdy, e_busy, e_ack_k, e_ack_p, e_ok, e_err, e_last;
   logic [127:0] e_msg;

   initial forever begin
      @(posedge clock or negedge RESETN);
      if (!RESETN) begin
         m_c = 0; m_active = 1'b0; m_free_at = 0; m_done_prev = 1'b0;
         m_load_at = -1; m_from = -1; m_to = -1; m_att = 0; m_win = 1'b0;
         e_drdy = 1'b0; e_busy = 1'b0; e_ack_k = 1'b0; e_ack_p = 1'b0;
         e_ok = 1'b0; e_err = 1'b0; e_last = 1'b1; e_msg = {16{8'h20}};
      end else begin
         // inputs seen now belong to cycle m_c; outputs computed for m_c+1
         m_c = m_c + 1;
         e_ack_k = 1'b0; e_ack_p = 1'b0; e_ok = 1'b0; e_err = 1'b0;
         if (m_active && (m_c - 1 == m_load_at)) begin
            e_last = m_win;
            e_msg  = m_win ? preset_text(preset_sel) : msg_kbd;
         end
         if (m_active && (m_c - 1 >= m_from) && (m_c - 1 <= m_to)) begin
            if (done && !m_done_prev) begin
               e_ok = 1'b1; m_active = 1'b0; m_free_at = m_c + G_CYC;
            end else if (m_c - 1 == m_to) begin
               if (m_att < EFF_RETRY) begin
                  m_att++; m_from = m_c + G_CYC; m_to = m_from + T_CYC - 1;
               end else begin
                  e_err = 1'b1; m_active = 1'b0; m_free_at = m_c + G_CYC;
               end
            end
         end else if (!m_active && (m_c - 1 >= m_free_at) && (req_kbd || req_preset)) begin
            m_win = (req_kbd && req_preset) ? !e_last : req_preset;
            m_active = 1'b1; m_load_at = m_c; m_from = m_c + 1; m_to = m_c + T_CYC; m_att = 0;
            if (m_win) e_ack_p = 1'b1; else e_ack_k = 1'b1;
         end
         m_done_prev = done;
         e_drdy = m_active && (m_c >= m_from) && (m_c <= m_to);
         e_busy = m_active || (m_c < m_free_at);
      end
   end

   // Compare process: every output against the model, mid-cycle.
   initial forever begin
      @(negedge clock);
      if (chk_en) begin
         chk("data_ready", data_ready, e_drdy);
         chk("busy", busy, e_busy);
         chk("ack_kbd", ack_kbd, e_ack_k);
         chk("ack_preset", ack_preset, e_ack_p);
         chk("tx_ok", tx_ok, e_ok);
         chk("tx_err", tx_err, e_err);
         chk("last_grant", last_grant, e_last);
         chk("message_out", message_out, e_msg);
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic do_reset();
      RESETN = 1'b0; req_kbd = 1'b0; req_preset = 1'b0; done = 1'b0;
      tick(); tick();
      RESETN = 1'b1;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 120 && !ok; k++) begin
         if (!busy) ok = 1'b1;
         else tick();
      end
      chk("idle_wait", ok, 1'b1);
   endtask

   // Wait for data_ready, then raise done two cycles later and expect tx_ok.
   task automatic serve_done();
      bit seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         if (data_ready) seen = 1'b1;
         else tick();
      end
      chk("drdy_wait", seen, 1'b1);
      tick(); tick();
      done = 1'b1;
      tick();
      chk("served_tx_ok", tx_ok, 1'b1);
      done = 1'b0;
   endtask

   initial begin
      logic [127:0] hi_msg;
      logic [127:0] r_msg;
      bit           bits[$];
      int           hi_runs[$];
      int           lo_runs[$];
      int           run;
      bit           cur;
      bit           err_seen;
      bit           got;

      RESETN = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_message", message_out, {16{8'h20}});
      chk("rst_last_grant", last_grant, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drdy", data_ready, 1'b0);

      // keyboard "HI": ack at 1, data at 2, done at 10, tx_ok at 11
      RESETN = 1'b1;
      hi_msg = {{14{8'h20}}, 8'h49, 8'h48};
      msg_kbd = hi_msg; req_kbd = 1'b1;
      tick();
      chk("hi_ack", ack_kbd, 1'b1);
      req_kbd = 1'b0;
      tick();
      chk("hi_drdy", data_ready, 1'b1);
      chk("hi_msg", message_out, hi_msg);
      repeat (8) tick();
      done = 1'b1;
      tick();
      chk("hi_tx_ok", tx_ok, 1'b1);
      chk("hi_drdy_low", data_ready, 1'b0);
      done = 1'b0;
      wait_idle();

      // tie from reset: keyboard first, then the smiley preset
      do_reset();
      msg_kbd = {$urandom, $urandom, $urandom, $urandom};
      req_kbd = 1'b1; req_preset = 1'b1; preset_sel = 2'b00;
      tick();
      chk("tie_ack_kbd", ack_kbd, 1'b1);
      chk("tie_ack_preset", ack_preset, 1'b0);
      req_kbd = 1'b0;
      serve_done();
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         tick();
         if (ack_preset) got = 1'b1;
      end
      chk("tie_preset_ack_wait", got, 1'b1);
      req_preset = 1'b0;
      tick();
      chk("smiley_lo16", message_out[15:0], 16'h293A);
      chk("smiley_last_grant", last_grant, 1'b1);
      serve_done();
      wait_idle();

      // reserved preset latches spaces and completes normally
      req_preset = 1'b1; preset_sel = 2'b11;
      tick();
      chk("sel11_ack", ack_preset, 1'b1);
      req_preset = 1'b0;
      tick();
      chk("sel11_msg", message_out, {16{8'h20}});
      serve_done();
      wait_idle();

      // done already high at SEND entry: only the fresh rise (cycle 12) counts
      done = 1'b1; req_kbd = 1'b1; msg_kbd = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 1) req_kbd = 1'b0;
         chk("held_done_tx_ok", tx_ok, (k == 13) ? 1'b1 : 1'b0);
         if (k == 8) done = 1'b0;
         if (k == 12) done = 1'b1;
      end
      done = 1'b0;
      wait_idle();

      // done never rises: timed-out attempts then tx_err
      req_kbd = 1'b1; msg_kbd = {$urandom, $urandom, $urandom, $urandom};
      tick();
      req_kbd = 1'b0;
      err_seen = 1'b0;
      for (int k = 0; k < 300 && !err_seen; k++) begin
         bits.push_back(data_ready);
         if (tx_err) err_seen = 1'b1;
         else tick();
      end
      chk("to_err_seen", err_seen, 1'b1);
      run = 0; cur = 1'b0;
      foreach (bits[i]) begin
         if (bits[i] == cur) run++;
         else begin
            if (cur) hi_runs.push_back(run);
            else if (hi_runs.size() > 0) lo_runs.push_back(run);
            cur = bits[i]; run = 1;
         end
      end
      chk("to_pulses", hi_runs.size(), EFF_RETRY + 1);
      foreach (hi_runs[i]) chk("to_pulse_len", hi_runs[i], T_CYC);
      foreach (lo_runs[i]) chk("to_gap_len", lo_runs[i], G_CYC);
      wait_idle();

      // asynchronous reset in the middle of SEND
      req_kbd = 1'b1; msg_kbd = {$urandom, $urandom, $urandom, $urandom};
      tick();
      req_kbd = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_drdy", data_ready, 1'b1);
      #3;
      RESETN = 1'b0;
      #1;
      chk("async_rst_drdy", data_ready, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
      tick();
      RESETN = 1'b1;
      tick();
      chk("post_rst_msg", message_out, {16{8'h20}});
      chk("post_rst_busy", busy, 1'b0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (i == 1500) RESETN = 1'b0;
         if (i == 1503) RESETN = 1'b1;
         if (req_kbd && ack_kbd) req_kbd = 1'b0;
         else if (!req_kbd && $urandom_range(0, 7) == 0) begin
            req_kbd = 1'b1;
            r_msg = {$urandom, $urandom, $urandom, $urandom};
            msg_kbd = r_msg;
         end
         if (req_preset && ack_preset) req_preset = 1'b0;
         else if (!req_preset && $urandom_range(0, 7) == 0) begin
            req_preset = 1'b1;
            preset_sel = 2'($urandom_range(0, 3));
         end
         case ((i / 150) % 3)
            0:       done = 1'b0;
            1:       done = ($urandom_range(0, 3) == 0);
            default: begin
               if (data_ready && $urandom_range(0, 7) == 0) done = 1'b1;
               else if (done && $urandom_range(0, 3) == 0) done = 1'b0;
            end
         endcase
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
